// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one Avalon-MM host port between a burst reader and a burst writer.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_address,
    input  logic              rd_read,
    input  logic [BCNT_W-1:0] rd_burstcount,
    output logic [DATA_W-1:0] rd_readdata,
    output logic              rd_readdatavalid,
    output logic              rd_waitrequest,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [DATA_W-1:0] wr_writedata,
    input  logic              wr_write,
    input  logic [BCNT_W-1:0] wr_burstcount,
    output logic              wr_waitrequest,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_writedata,
    output logic              m_read,
    output logic              m_write,
    output logic [BCNT_W-1:0] m_burstcount,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    input  logic              m_waitrequest,
    output logic              grant_rd,
    output logic              grant_wr,
    output logic              stray_rdv
);
    typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_BURST} state_e;
    state_e            state_q, state_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic              last_wr_q, last_wr_d, stray_q, stray_d;
    logic              in_rd_cmd, in_rd_data, in_wr;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_wr_q <= 1'b1;
            stray_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_wr_q <= last_wr_d;
            stray_q   <= stray_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_wr_d = last_wr_q;
        stray_d   = stray_q | (m_readdatavalid && state_q != RD_DATA);
        case (state_q)
            IDLE:
                if (rd_read && (!wr_write || last_wr_q)) state_d = RD_CMD;
                else if (wr_write) begin
                    state_d = WR_BURST;
                    cnt_d   = (wr_burstcount == '0) ? BCNT_W'(1) : wr_burstcount;
                end
            RD_CMD:
                if (rd_read && !m_waitrequest) begin
                    state_d = RD_DATA;
                    cnt_d   = (rd_burstcount == '0) ? BCNT_W'(1) : rd_burstcount;
                end
            RD_DATA:
                if (m_readdatavalid) begin
                    cnt_d = (cnt_q == '0) ? '0 : cnt_q - BCNT_W'(1);
                    if (cnt_q <= BCNT_W'(1)) begin
                        state_d   = IDLE;
                        last_wr_d = 1'b0;
                    end
                end
            WR_BURST:
                if (wr_write && !m_waitrequest) begin
                    cnt_d = (cnt_q == '0) ? '0 : cnt_q - BCNT_W'(1);
                    if (cnt_q <= BCNT_W'(1)) begin
                        state_d   = IDLE;
                        last_wr_d = 1'b1;
                    end
                end
        endcase
    end
    // Outputs are gated by reset so the host port is quiet while reset is held.
    assign in_rd_cmd        = reset && state_q == RD_CMD;
    assign in_rd_data       = reset && state_q == RD_DATA;
    assign in_wr            = reset && state_q == WR_BURST;
    assign m_read           = in_rd_cmd && rd_read;
    assign m_write          = in_wr && wr_write;
    assign m_address        = in_wr ? wr_address : rd_address;
    assign m_writedata      = wr_writedata;
    assign m_burstcount     = in_wr ? wr_burstcount : rd_burstcount;
    assign rd_waitrequest   = in_rd_cmd ? m_waitrequest : 1'b1;
    assign wr_waitrequest   = in_wr ? m_waitrequest : 1'b1;
    assign rd_readdatavalid = in_rd_data && m_readdatavalid;
    assign rd_readdata      = m_readdata;
    assign grant_rd         = in_rd_cmd || in_rd_data;
    assign grant_wr         = in_wr;
    assign stray_rdv        = stray_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transaction checks of mem_port_arbiter against a round-robin transaction model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rd_address = '0, wr_address = '0, wr_writedata = '0, m_readdata = '0;
  logic        rd_read = 1'b0, wr_write = 1'b0, m_readdatavalid = 1'b0, m_waitrequest = 1'b0;
  logic [15:0] rd_burstcount = '0, wr_burstcount = '0;
  logic [31:0] rd_readdata, m_address, m_writedata;
  logic [15:0] m_burstcount;
  logic        rd_readdatavalid, rd_waitrequest, wr_waitrequest, m_read, m_write;
  logic        grant_rd, grant_wr, stray_rdv;
  int          checks = 0, errors = 0;
  logic        last_wr, rd_pend, wr_pend, exp_stray, mid_rd, gaps;
  int          rd_cs, ws_beat, ws_len;
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .rd_address(rd_address), .rd_read(rd_read), .rd_burstcount(rd_burstcount),
    .rd_readdata(rd_readdata), .rd_readdatavalid(rd_readdatavalid), .rd_waitrequest(rd_waitrequest),
    .wr_address(wr_address), .wr_writedata(wr_writedata), .wr_write(wr_write),
    .wr_burstcount(wr_burstcount), .wr_waitrequest(wr_waitrequest),
    .m_address(m_address), .m_writedata(m_writedata), .m_read(m_read), .m_write(m_write),
    .m_burstcount(m_burstcount), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_waitrequest(m_waitrequest), .grant_rd(grant_rd), .grant_wr(grant_wr), .stray_rdv(stray_rdv)
  );
  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", t, o, e);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; rd_read = 1'b0; wr_write = 1'b0; m_readdatavalid = 1'b1; m_waitrequest = 1'b0;
    #1 chk("rst_out", {m_read, m_write, rd_readdatavalid, grant_rd, grant_wr, rd_waitrequest, wr_waitrequest}, 7'b0000011);
    @(negedge clk);
    m_readdatavalid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rst_stray", stray_rdv, 1'b0);
    last_wr = 1'b1; rd_pend = 1'b0; wr_pend = 1'b0; exp_stray = 1'b0;
  endtask
  task automatic serve_read();
    int n;
    n = (rd_burstcount == 0) ? 1 : int'(rd_burstcount);
    for (int i = 0; i < rd_cs; i++) begin
      m_waitrequest = 1'b1;
      #1 chk("rd_cmd_stall", {rd_waitrequest, m_read}, 2'b11);
      @(negedge clk);
    end
    m_waitrequest = 1'b0;
    #1 chk("rd_cmd", {m_read, rd_waitrequest, wr_waitrequest, m_write}, 4'b1010);
    chk("rd_cmd_addr", m_address, rd_address);
    chk("rd_cmd_bcnt", m_burstcount, rd_burstcount);
    @(negedge clk);
    rd_read = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        m_readdatavalid = 1'b0;
        #1 chk("rd_gap", {rd_readdatavalid, grant_rd, rd_waitrequest}, 3'b011);
        @(negedge clk);
      end
      m_readdatavalid = 1'b1;
      m_readdata = $urandom;
      #1 chk("rd_beat", {rd_readdatavalid, m_read, grant_rd, wr_waitrequest}, 4'b1011);
      chk("rd_data", rd_readdata, m_readdata);
      @(negedge clk);
    end
    m_readdatavalid = 1'b0;
    #1 chk("rd_done", {grant_rd, grant_wr, m_read}, 3'b000);
  endtask
  task automatic serve_write();
    int n;
    n = (wr_burstcount == 0) ? 1 : int'(wr_burstcount);
    for (int b = 0; b < n; b++) begin
      if (mid_rd && b == 1) begin rd_read = 1'b1; rd_pend = 1'b1; end
      if (b == ws_beat) begin
        for (int s = 0; s < ws_len; s++) begin
          m_waitrequest = 1'b1;
          #1 chk("wr_stall", {wr_waitrequest, m_write, rd_waitrequest, grant_wr}, 4'b1111);
          @(negedge clk);
        end
      end
      m_waitrequest = 1'b0;
      wr_writedata = $urandom;
      #1 chk("wr_beat", {m_write, wr_waitrequest, rd_waitrequest, grant_wr, grant_rd, m_read}, 6'b101100);
      chk("wr_data", m_writedata, wr_writedata);
      chk("wr_addr", m_address, wr_address);
      chk("wr_bcnt", m_burstcount, wr_burstcount);
      @(negedge clk);
    end
    wr_write = 1'b0;
    #1 chk("wr_done", {grant_wr, grant_rd, m_write}, 3'b000);
  endtask
  task automatic arb();
    logic exp_rd;
    rd_read = rd_pend;
    wr_write = wr_pend;
    #1 chk("idle", {rd_waitrequest, wr_waitrequest, m_read, m_write, grant_rd, grant_wr}, 6'b110000);
    @(negedge clk);
    exp_rd = rd_pend && (!wr_pend || last_wr);
    #1 chk("grant_rd", grant_rd, exp_rd);
    chk("grant_wr", grant_wr, !exp_rd);
    if (exp_rd) begin
      serve_read();
      rd_pend = 1'b0; last_wr = 1'b0;
    end else begin
      serve_write();
      wr_pend = 1'b0; last_wr = 1'b1;
    end
    chk("stray_hold", stray_rdv, exp_stray);
  endtask
  initial begin
    rd_cs = 0; gaps = 1'b0; mid_rd = 1'b0; ws_beat = 0; ws_len = 0;
    do_reset();
    rd_pend = 1'b1; rd_burstcount = 16'd4; rd_address = $urandom;
    arb();
    do_reset();
    rd_pend = 1'b1; wr_pend = 1'b1; rd_burstcount = 16'd2; wr_burstcount = 16'd2;
    rd_address = $urandom; wr_address = $urandom;
    arb();
    arb();
    rd_pend = 1'b1; wr_pend = 1'b1; rd_burstcount = 16'd1;
    arb();
    arb();
    wr_pend = 1'b1; wr_burstcount = 16'd3; ws_beat = 1; ws_len = 2; mid_rd = 1'b1;
    rd_burstcount = 16'd2;
    arb();
    mid_rd = 1'b0; ws_len = 0;
    arb();
    rd_pend = 1'b1; rd_burstcount = 16'd0;
    arb();
    @(negedge clk);
    m_readdatavalid = 1'b1;
    #1 chk("stray_fwd", {rd_readdatavalid, grant_rd}, 2'b00);
    @(negedge clk);
    m_readdatavalid = 1'b0;
    #1 chk("stray_set", stray_rdv, 1'b1);
    exp_stray = 1'b1;
    wr_pend = 1'b1; wr_burstcount = 16'd2;
    arb();
    do_reset();
    rd_pend = 1'b1; rd_burstcount = 16'd8; rd_read = 1'b1;
    @(negedge clk);
    #1 chk("r8_grant", {grant_rd, m_read}, 2'b11);
    @(negedge clk);
    rd_read = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_readdatavalid = 1'b1;
      #1 chk("r8_beat", rd_readdatavalid, 1'b1);
      @(negedge clk);
    end
    do_reset();
    for (int k = 0; k < 3; k++) begin
      m_readdatavalid = 1'b1;
      #1 chk("r8_after_rst", {rd_readdatavalid, grant_rd}, 2'b00);
      @(negedge clk);
    end
    m_readdatavalid = 1'b0;
    #1 chk("r8_stray", stray_rdv, 1'b1);
    do_reset();
    gaps = 1'b1;
    for (int it = 0; it < 40; it++) begin
      if (!rd_pend && $urandom_range(0, 1) == 1) begin
        rd_pend = 1'b1; rd_burstcount = 16'($urandom_range(0, 5)); rd_address = $urandom;
      end
      if (!wr_pend && ($urandom_range(0, 1) == 1 || !rd_pend)) begin
        wr_pend = 1'b1; wr_burstcount = 16'($urandom_range(0, 5)); wr_address = $urandom;
      end
      rd_cs = $urandom_range(0, 2);
      ws_beat = $urandom_range(0, 3);
      ws_len = $urandom_range(0, 2);
      mid_rd = !rd_pend && $urandom_range(0, 1) == 1;
      if (mid_rd) begin rd_burstcount = 16'($urandom_range(0, 5)); rd_address = $urandom; end
      arb();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32, data width of all ports.
REQ-003 SHALL have parameter BCNT_W, default 16, burstcount width of all ports.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-low.
REQ-006 rd_address, rd_read, rd_burstcount  in  ADDR_W/1/BCNT_W  read-requester (capture read path) command.
REQ-007 rd_readdata, rd_readdatavalid, rd_waitrequest  out  DATA_W/1/1  read-requester response and stall.
REQ-008 wr_address, wr_writedata, wr_write, wr_burstcount  in  ADDR_W/DATA_W/1/BCNT_W  write-requester (capture write path) command.
REQ-009 wr_waitrequest  out  1  write-requester stall.
REQ-010 m_address, m_writedata, m_read, m_write, m_burstcount  out  ADDR_W/DATA_W/1/1/BCNT_W  shared Avalon-MM memory host port.
REQ-011 m_readdata, m_readdatavalid, m_waitrequest  in  DATA_W/1/1  memory response and stall.
REQ-012 grant_rd, grant_wr  out  1/1  current owner, one-hot or both low.
REQ-013 stray_rdv  out  1  sticky flag: readdatavalid seen with no read burst outstanding.

Function
REQ-014 SHALL implement FSM states IDLE, RD_CMD, RD_DATA, WR_BURST.
REQ-015 IDLE: requests are rd_read and wr_write; if exactly one is high, that requester SHALL be granted; if both are high, the requester not granted last SHALL win (round-robin).
REQ-016 Grant SHALL take effect the cycle after the request is sampled in IDLE; m_read or m_write SHALL assert no earlier than that cycle (1-cycle arbitration latency).
REQ-017 In IDLE, rd_waitrequest and wr_waitrequest SHALL be 1, and m_read and m_write SHALL be 0.
REQ-018 RD_CMD: m_address, m_burstcount and m_read SHALL pass through from the rd_ inputs; rd_waitrequest SHALL equal m_waitrequest; wr_waitrequest SHALL be 1.
REQ-019 RD_CMD: on m_read && !m_waitrequest, the FSM SHALL go to RD_DATA and load the beat counter with rd_burstcount; a burstcount of 0 SHALL be treated as 1.
REQ-020 RD_DATA: m_read SHALL be 0 and rd_waitrequest 1; rd_readdatavalid SHALL equal m_readdatavalid; rd_readdata SHALL equal m_readdata; the counter SHALL decrement per valid beat.
REQ-021 RD_DATA: the valid beat that brings the counter to 0 SHALL cause a transition to IDLE the next cycle, with last-grant set to RD.
REQ-022 WR_BURST: on grant, the beat counter SHALL load wr_burstcount (0 treated as 1); m_address, m_writedata, m_burstcount and m_write SHALL pass through from the wr_ inputs; wr_waitrequest SHALL equal m_waitrequest.
REQ-023 WR_BURST: each beat with m_write && !m_waitrequest SHALL decrement the counter; the final beat SHALL cause IDLE the next cycle, with last-grant set to WR.
REQ-024 The requester not granted SHALL see waitrequest = 1 throughout and SHALL never receive readdatavalid.
REQ-025 grant_rd SHALL be 1 in RD_CMD and RD_DATA; grant_wr SHALL be 1 in WR_BURST; otherwise both SHALL be 0.
REQ-026 m_readdatavalid outside RD_DATA SHALL NOT be forwarded and SHALL set stray_rdv to 1 until reset.
REQ-027 A write burst SHALL never be pre-empted mid-burst; a pending read SHALL wait until the write burst completes.
REQ-028 The beat counter SHALL be BCNT_W bits and SHALL saturate at 0 (no wrap).

Reset
REQ-029 When reset = 0 at a clock edge, the FSM SHALL go to IDLE and the counter to 0; last-grant SHALL become WR so that read wins the first tie; stray_rdv SHALL become 0.
REQ-030 During reset, m_read, m_write, rd_readdatavalid, grant_rd and grant_wr SHALL be 0, and rd_waitrequest and wr_waitrequest SHALL be 1.
REQ-031 Reset asserted mid-burst SHALL abandon the burst; no further beats SHALL be counted or forwarded.

Verification
REQ-032 Read only: rd_read=1, rd_burstcount=4, m_waitrequest=0 -> m_read high 1 cycle after request; 4 readdatavalid beats forwarded; IDLE after beat 4; grant_rd low.
REQ-033 Tie after reset: rd_read=wr_write=1 at the same cycle -> read granted first; once the read completes with wr_write still high, the write is granted next; on a second tie, read is granted again.
REQ-034 Write with stall: wr_burstcount=3, m_waitrequest high 2 cycles on beat 2 -> wr_waitrequest mirrors the stall; exactly 3 beats counted; a read requested mid-burst is held (rd_waitrequest=1) until IDLE.
REQ-035 Burstcount 0: rd_burstcount=0 -> treated as 1; one readdatavalid returns to IDLE.
REQ-036 Stray data: m_readdatavalid=1 in IDLE -> rd_readdatavalid=0, stray_rdv=1 and held until reset.
REQ-037 Reset mid read burst after 2 of 8 beats -> IDLE, grant_rd=0; later readdatavalid beats not forwarded (stray_rdv sets).
